// File: rtl/fft_bfly_addr_gen.sv
// Radix-2 DIT FFT address generator.
// Walks every stage and butterfly of an in-place N = 2^LOG2N point transform.
// For each butterfly it emits the operand address pair and the twiddle index
// on a valid/ready stream.
// Optional macro FFT_AGU_BITREV_EN adds a bit-reversal pass before the first
// stage. That pass emits one (j, bitrev(j)) beat for each point.
module fft_bfly_addr_gen #(
  parameter int unsigned LOG2N = 5,
  parameter int unsigned SW    = 3
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LOG2N-1:0]   addr_a,
  output logic [LOG2N-1:0]   addr_b,
  output logic [LOG2N-2:0]   tw_idx,
  output logic [SW-1:0]      stage,
  output logic               last_in_stage
);

  localparam int unsigned KW = LOG2N - 1;
  localparam int unsigned N  = 1 << LOG2N;

  localparam logic [KW-1:0]    K_LAST = KW'(N / 2 - 1);
  localparam logic [SW-1:0]    S_LAST = SW'(LOG2N - 1);
  localparam logic [LOG2N-1:0] J_LAST = LOG2N'(N - 1);

`ifdef FFT_AGU_BITREV_EN
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_BITREV} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_RUN} state_t;
`endif

  state_t state_q, state_d;

  logic [SW-1:0]    s_q, s_d;
  logic [KW-1:0]    k_q, k_d;
  logic [LOG2N-1:0] j_q, j_d;

  logic             busy_d, done_d, valid_d, last_d;
  logic [LOG2N-1:0] a_d, b_d;
  logic [KW-1:0]    tw_d;
  logic [SW-1:0]    stage_d;
  logic             load_run, load_br, accept;

  // Upper-wing address: the group base is grp*2^(s+1), plus the offset inside the group.
  function automatic logic [LOG2N-1:0] bfly_a(input logic [SW-1:0] s, input logic [KW-1:0] k);
    logic [LOG2N-1:0] kk, mask, pos, grp;
    kk   = LOG2N'(k);
    mask = (LOG2N'(1) << s) - LOG2N'(1);
    pos  = kk & mask;
    grp  = kk >> s;
    return ((grp << s) << 1) | pos;
  endfunction

  // Twiddle index: the offset inside the group, scaled up to the full-length ROM.
  function automatic logic [KW-1:0] bfly_tw(input logic [SW-1:0] s, input logic [KW-1:0] k);
    logic [LOG2N-1:0] mask, sh;
    mask = (LOG2N'(1) << s) - LOG2N'(1);
    sh   = (LOG2N'(k) & mask) << (SW'(LOG2N - 1) - s);
    return KW'(sh);
  endfunction

  // Reverse the bits of the point index over LOG2N bits.
  function automatic logic [LOG2N-1:0] bit_rev(input logic [LOG2N-1:0] j);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < int'(LOG2N); i++) r[i] = j[LOG2N-1-i];
    return r;
  endfunction

  // Next-state, counter and output-register logic.
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    k_d      = k_q;
    j_d      = j_q;
    busy_d   = busy;
    done_d   = 1'b0;
    valid_d  = out_valid;
    a_d      = addr_a;
    b_d      = addr_b;
    tw_d     = tw_idx;
    stage_d  = stage;
    last_d   = last_in_stage;
    load_run = 1'b0;
    load_br  = 1'b0;
    accept   = out_valid & out_ready;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          s_d     = '0;
          k_d     = '0;
          j_d     = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
`ifdef FFT_AGU_BITREV_EN
          state_d = ST_BITREV;
          load_br = 1'b1;
`else
          state_d  = ST_RUN;
          load_run = 1'b1;
`endif
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (s_q == S_LAST && k_q == K_LAST) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            if (k_q == K_LAST) begin
              k_d = '0;
              s_d = s_q + SW'(1);
            end else begin
              k_d = k_q + KW'(1);
            end
            load_run = 1'b1;
          end
        end
      end
`ifdef FFT_AGU_BITREV_EN
      ST_BITREV: begin
        if (accept) begin
          if (j_q == J_LAST) begin
            state_d  = ST_RUN;
            s_d      = '0;
            k_d      = '0;
            load_run = 1'b1;
          end else begin
            j_d     = j_q + LOG2N'(1);
            load_br = 1'b1;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (load_run) begin
      a_d     = bfly_a(s_d, k_d);
      b_d     = bfly_a(s_d, k_d) + (LOG2N'(1) << s_d);
      tw_d    = bfly_tw(s_d, k_d);
      stage_d = s_d;
      last_d  = (k_d == K_LAST);
    end

    if (load_br) begin
      a_d     = j_d;
      b_d     = bit_rev(j_d);
      tw_d    = '0;
      stage_d = '0;
      last_d  = (j_d == J_LAST);
    end

    // Abort wins over start and over beat acceptance.
    if (abort) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q       <= ST_IDLE;
      s_q           <= '0;
      k_q           <= '0;
      j_q           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      out_valid     <= 1'b0;
      addr_a        <= '0;
      addr_b        <= '0;
      tw_idx        <= '0;
      stage         <= '0;
      last_in_stage <= 1'b0;
    end else begin
      state_q       <= state_d;
      s_q           <= s_d;
      k_q           <= k_d;
      j_q           <= j_d;
      busy          <= busy_d;
      done          <= done_d;
      out_valid     <= valid_d;
      addr_a        <= a_d;
      addr_b        <= b_d;
      tw_idx        <= tw_d;
      stage         <= stage_d;
      last_in_stage <= last_d;
    end
  end

endmodule

// File: tb/tb_fft_bfly_addr_gen.sv
// Self-checking bench for fft_bfly_addr_gen with LOG2N=3.
// The expected beat list is built from the butterfly group/offset structure.
// The bit-reversal pass is included when FFT_AGU_BITREV_EN is defined.
module tb_fft_bfly_addr_gen;

  localparam int unsigned L   = 3;
  localparam int unsigned SWB = 2;
  localparam int unsigned N   = 1 << L;
`ifdef FFT_AGU_BITREV_EN
  localparam int OFF = N;
`else
  localparam int OFF = 0;
`endif

  typedef struct packed {
    logic [L-1:0]   a;
    logic [L-1:0]   b;
    logic [L-2:0]   tw;
    logic [SWB-1:0] st;
    logic           last;
  } beat_t;

  logic           clk = 1'b0;
  logic           clr_n, start, abort, out_ready;
  logic           busy, done, out_valid, last_in_stage;
  logic [L-1:0]   addr_a, addr_b;
  logic [L-2:0]   tw_idx;
  logic [SWB-1:0] stage;

  int    total = 0;
  int    bad   = 0;
  beat_t expq[$];

  fft_bfly_addr_gen #(.LOG2N(L), .SW(SWB)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
    .addr_a(addr_a), .addr_b(addr_b), .tw_idx(tw_idx), .stage(stage),
    .last_in_stage(last_in_stage)
  );

  always #5 clk = ~clk;

  // Reference schedule: optional bit-reversal pass, then stages of groups of butterflies.
  task automatic build_expected();
    beat_t bt;
    int    c;
    expq.delete();
`ifdef FFT_AGU_BITREV_EN
    for (int j = 0; j < int'(N); j++) begin
      int r, x;
      r = 0;
      x = j;
      for (int i = 0; i < int'(L); i++) begin
        r = r * 2 + x % 2;
        x = x / 2;
      end
      bt.a = L'(j); bt.b = L'(r); bt.tw = '0; bt.st = '0; bt.last = (j == int'(N) - 1);
      expq.push_back(bt);
    end
`endif
    for (int st = 0; st < int'(L); st++) begin
      int half;
      half = 1 << st;
      c = 0;
      for (int base = 0; base < int'(N); base += 2 * half) begin
        for (int p = 0; p < half; p++) begin
          bt.a    = L'(base + p);
          bt.b    = L'(base + p + half);
          bt.tw   = (L - 1)'(p * (int'(N) / (2 * half)));
          bt.st   = SWB'(st);
          bt.last = (c == int'(N) / 2 - 1);
          expq.push_back(bt);
          c++;
        end
      end
    end
  endtask

  // Drive one transform (start already pulsed by the caller) and check every beat and the done pulse.
  task automatic run_beats(input int rmode, input int stall_idx, input int start_mid, input bit restart);
    int idx, cyc, stall_cnt;
    bit r;
    idx = 0; cyc = 0; stall_cnt = 0;
    while (idx < expq.size() && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      total++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
        bad++;
        $display("FAIL run_ctrl beat %0d: valid=%b busy=%b done=%b, want 1 1 0", idx, out_valid, busy, done);
      end
      total++;
      if ({addr_a, addr_b, tw_idx, stage, last_in_stage} !== expq[idx]) begin
        bad++;
        $display("FAIL beat %0d: got a=%0d b=%0d tw=%0d st=%0d last=%b, want a=%0d b=%0d tw=%0d st=%0d last=%b",
                 idx, addr_a, addr_b, tw_idx, stage, last_in_stage,
                 expq[idx].a, expq[idx].b, expq[idx].tw, expq[idx].st, expq[idx].last);
      end
      r = (rmode == 1) ? ($urandom_range(0, 99) < 60) : 1'b1;
      if (idx == stall_idx && stall_cnt < 3) begin
        r = 1'b0;
        stall_cnt++;
      end
      if (idx == start_mid) start = 1'b1;
      out_ready = r;
      if (r) idx++;
    end
    total++;
    if (idx != expq.size()) begin
      bad++;
      $display("FAIL beat_count: accepted %0d beats, want %0d", idx, expq.size());
    end
    @(negedge clk);
    total++;
    if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse: done=%b valid=%b busy=%b, want 1 0 0", done, out_valid, busy);
    end
    out_ready = 1'b1;
    start = restart;
    if (!restart) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL done_width: done=%b valid=%b busy=%b, want 0 0 0", done, out_valid, busy);
      end
    end
  endtask

  // Run beats with ready held high until `target` beats have been accepted.
  task automatic advance_to(input int target);
    int idx, cyc;
    idx = 0; cyc = 0;
    while (idx < target && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      out_ready = 1'b1;
      total++;
      if (out_valid !== 1'b1 || {addr_a, addr_b, tw_idx, stage, last_in_stage} !== expq[idx]) begin
        bad++;
        $display("FAIL advance beat %0d: valid=%b a=%0d b=%0d tw=%0d, want valid=1 a=%0d b=%0d tw=%0d",
                 idx, out_valid, addr_a, addr_b, tw_idx, expq[idx].a, expq[idx].b, expq[idx].tw);
      end
      if (out_valid) idx++;
    end
  endtask

  task automatic test_reset();
    clr_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, out_valid, addr_a, addr_b, tw_idx, stage, last_in_stage} !== '0) begin
      bad++;
      $display("FAIL reset_values: got %h, want 0", {busy, done, out_valid, addr_a, addr_b, tw_idx, stage, last_in_stage});
    end
    clr_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({busy, done, out_valid, addr_a, addr_b, tw_idx, stage, last_in_stage} !== '0) begin
        bad++;
        $display("FAIL idle_cycle %0d: got %h, want 0", i, {busy, done, out_valid, addr_a, addr_b, tw_idx, stage, last_in_stage});
      end
    end
  endtask

  task automatic test_schedule();
    @(negedge clk); start = 1'b1; out_ready = 1'b1;
    run_beats(0, -1, -1, 1'b0);
  endtask

  task automatic test_backpressure();
    @(negedge clk); start = 1'b1; out_ready = 1'b1;
    run_beats(0, OFF + 5, -1, 1'b0);
  endtask

  task automatic test_random_ready();
    for (int t = 0; t < 3; t++) begin
      @(negedge clk); start = 1'b1;
      run_beats(1, -1, -1, 1'b0);
    end
  endtask

  task automatic test_start_mid_run();
    @(negedge clk); start = 1'b1; out_ready = 1'b1;
    run_beats(0, -1, OFF + 6, 1'b0);
  endtask

  task automatic test_back_to_back();
    @(negedge clk); start = 1'b1; out_ready = 1'b1;
    run_beats(0, -1, -1, 1'b1);
    run_beats(1, -1, -1, 1'b0);
  endtask

  task automatic test_abort();
    @(negedge clk); start = 1'b1; out_ready = 1'b1;
    advance_to(OFF + 4);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || {addr_a, addr_b, tw_idx, stage, last_in_stage} !== expq[OFF + 4]) begin
      bad++;
      $display("FAIL abort_beat: valid=%b a=%0d b=%0d, want valid=1 a=%0d b=%0d", out_valid, addr_a, addr_b,
               expq[OFF + 4].a, expq[OFF + 4].b);
    end
    abort = 1'b1; out_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL abort_exit: valid=%b busy=%b done=%b, want 0 0 0", out_valid, busy, done);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || done !== 1'b0) begin
        bad++;
        $display("FAIL abort_quiet %0d: valid=%b done=%b, want 0 0", i, out_valid, done);
      end
    end
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_over_start: valid=%b busy=%b, want 0 0", out_valid, busy);
    end
    start = 1'b1;
    run_beats(0, -1, -1, 1'b0);
  endtask

  task automatic test_async_reset();
    @(negedge clk); start = 1'b1; out_ready = 1'b1;
    advance_to(OFF + int'(N) / 2 + 1);
    @(negedge clk);
    #2 clr_n = 1'b0;
    #1;
    total++;
    if ({busy, done, out_valid, addr_a, addr_b, tw_idx, stage, last_in_stage} !== '0) begin
      bad++;
      $display("FAIL async_reset: got %h, want 0", {busy, done, out_valid, addr_a, addr_b, tw_idx, stage, last_in_stage});
    end
    @(negedge clk);
    clr_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({busy, done, out_valid} !== 3'b000) begin
        bad++;
        $display("FAIL post_reset %0d: busy/done/valid=%b, want 000", i, {busy, done, out_valid});
      end
    end
    @(negedge clk); start = 1'b1;
    run_beats(1, -1, -1, 1'b0);
  endtask

  initial begin
    build_expected();
    test_reset();
    test_schedule();
    test_backpressure();
    test_random_ready();
    test_start_mid_run();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_bfly_addr_gen.md
Name: fft_bfly_addr_gen

Overview:
- Parametrised successor to the single-width +1 incrementer.
- Sequences the full in-place radix-2 DIT FFT schedule for N = 2^LOG2N points.
- For each stage and butterfly it emits the operand address pair and the twiddle index over a valid/ready stream.
- Sits between the FFT controller (start/done) and the data-RAM/butterfly datapath.

Parameters:
- LOG2N, 5, log2 of FFT length; legal range 2..12.
- SW, 3, width of the stage index; must satisfy 2^SW >= LOG2N.

Ports:
- clk  in  1  rising-edge clock
- clr_n  in  1  asynchronous active-low reset
- start  in  1  begin a transform; sampled only in IDLE
- abort  in  1  synchronous; return to IDLE next cycle, no done
- busy  out  1  high in RUN (and BITREV when enabled)
- done  out  1  one-cycle pulse after last beat accepted
- out_valid  out  1  address beat valid
- out_ready  in  1  downstream accepts beat when valid & ready
- addr_a  out  LOG2N  upper-wing operand address
- addr_b  out  LOG2N  lower-wing operand address
- tw_idx  out  LOG2N-1  twiddle ROM index
- stage  out  SW  current stage, 0..LOG2N-1
- last_in_stage  out  1  beat is the final butterfly of its stage

Behaviour:
- All outputs registered. Reset (clr_n low, asynchronous) forces: state IDLE, busy=0, done=0, out_valid=0, addr_a=0, addr_b=0, tw_idx=0, stage=0, last_in_stage=0.
- Internal counters: stage s (SW bits) and butterfly k (LOG2N-1 bits).
- States:
  - IDLE: start=1 -> RUN with s=0, k=0. out_valid rises the cycle after start is sampled (latency 1).
  - RUN: beat accepted when out_valid & out_ready.
    - On accept with k < N/2-1: k <= k+1.
    - On accept with k = N/2-1 and s < LOG2N-1: k <= 0, s <= s+1.
    - On accept of the final beat (s = LOG2N-1, k = N/2-1): next cycle out_valid=0, busy=0, done=1 for exactly one cycle, state IDLE.
- Address math for span = 2^s, pos = k mod span, grp = k >> s:
  - addr_a = grp*2^(s+1) + pos
  - addr_b = addr_a + span
  - tw_idx = pos << (LOG2N-1-s)
  - All values are unsigned, truncated to the port width; no overflow is possible by construction.
- last_in_stage = 1 iff k = N/2-1.
- Stall: while out_valid=1 and out_ready=0, every output holds its value. No beat is dropped or repeated.
- start while busy: ignored. start in the done cycle: accepted, since the block is IDLE there; out_valid rises the next cycle.
- abort in any state: next cycle IDLE, out_valid=0, busy=0, done=0. abort has priority over start and over beat acceptance in the same cycle.
- clr_n asserted mid-transform: immediate reset values; no done pulse.
- Total beats per transform: LOG2N * 2^(LOG2N-1).

Optional Feature:
- Macro: FFT_AGU_BITREV_EN.
- Defined:
  - start enters BITREV before RUN.
  - BITREV emits N beats j = 0..N-1 on the same handshake, with addr_a = j and addr_b = bit-reverse(j) over LOG2N bits, tw_idx=0, stage=0.
  - last_in_stage=1 on j = N-1.
  - Downstream swaps the pair only when addr_a < addr_b.
  - After beat N-1 is accepted, the next cycle starts RUN at s=0, k=0 with no bubble. busy stays high throughout.
  - abort and reset rules are unchanged.
- Undefined: no BITREV state; start goes directly to RUN.

Test Plan:
- Reset/idle: LOG2N=3; hold clr_n=0 then release with no start -> all outputs 0 for 10 cycles.
- Schedule, out_ready=1: pulse start -> 12 beats (a,b,tw):
  - stage 0: (0,1,0) (2,3,0) (4,5,0) (6,7,0)
  - stage 1: (0,2,0) (1,3,2) (4,6,0) (5,7,2)
  - stage 2: (0,4,0) (1,5,1) (2,6,2) (3,7,3)
  - last_in_stage on beats 4, 8 and 12; done pulses 1 cycle after beat 12.
- Backpressure: drop out_ready for 3 cycles on beat (1,3,2) -> outputs frozen; the next accepted beat is (4,6,0); total accepted beats = 12.
- Control corners:
  - start asserted in the middle of RUN -> ignored.
  - abort on beat 5 -> out_valid=0 and busy=0 next cycle, no done; a fresh start then restarts from (0,1,0).
  - start asserted in the done cycle -> new transform begins next cycle.
- Async reset mid-run: clr_n low between clock edges during stage 1 -> outputs zero immediately.
- FFT_AGU_BITREV_EN defined, LOG2N=3: 8 beats with addr_b = 0,4,2,6,1,5,3,7, then the 12 RUN beats above; done 1 cycle after the last.
